alu_iter: RTL and testbench
===========================

ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 The module SHALL have parameter WIDTH, default 64, giving the operand and result width; legal values are powers of two from 8 to 64.
REQ-002 The module SHALL have derived parameter SHW, default $clog2(WIDTH), giving the shift-amount width.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: asynchronous active-high reset.
REQ-005 The module SHALL have port in_valid, input, 1 bit: the operation request is valid.
REQ-006 The module SHALL have port in_ready, output, 1 bit: the block can accept a request.
REQ-007 The module SHALL have port A, input, WIDTH bits: operand A.
REQ-008 The module SHALL have port B, input, WIDTH bits: operand B; for shifts, B[SHW-1:0] is the shift amount.
REQ-009 The module SHALL have port cntrl, input, 3 bits: the opcode.
REQ-010 The module SHALL have port out_valid, output, 1 bit: result and flags are valid.
REQ-011 The module SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 The module SHALL have port result, output, WIDTH bits: the operation result.
REQ-013 The module SHALL have ports zero, negative, carry_out and overflow, each output, 1 bit: the status flags.

Function
REQ-014 The opcodes SHALL be:
- 000: result = B
- 001: result = A logical-shift-left by B[SHW-1:0], one bit per cycle
- 010: result = A + B
- 011: result = A - B, computed as A + ~B + 1
- 100: result = A & B
- 101: result = A | B
- 110: result = A ^ B
- 111: result = A logical-shift-right by B[SHW-1:0], one bit per cycle
REQ-015 The FSM SHALL have states IDLE, SHIFT and DONE; in_ready SHALL be 1 only in IDLE.
REQ-016 A request SHALL be accepted on a rising edge where the state is IDLE and in_valid=1; A, B and cntrl SHALL be captured at that edge, and input changes after acceptance SHALL be ignored.
REQ-017 For non-shift opcodes, accepting a request SHALL move the FSM IDLE->DONE with result and flags registered in the same edge, giving out_valid=1 one cycle after acceptance.
REQ-018 For shift opcodes with amount n>0, accepting a request SHALL move the FSM IDLE->SHIFT with a counter loaded to n.
- Each SHIFT cycle SHALL shift the working register by one bit and decrement the counter.
- The FSM SHALL go SHIFT->DONE on the edge where the counter reaches 0.
- Total latency SHALL be n+1 edges.
REQ-019 A shift with n=0 SHALL go directly IDLE->DONE with result=A and carry_out=0.
REQ-020 In DONE, result and flags SHALL be held stable while out_valid=1 and out_ready=0.
REQ-021 On an edge where the state is DONE and out_ready=1, the FSM SHALL go DONE->IDLE and drop out_valid; a new request SHALL NOT be accepted on that same edge.
REQ-022 zero SHALL be 1 when result is all zeros, and negative SHALL equal result[WIDTH-1], for every opcode.
REQ-023 For add, carry_out SHALL be the carry out of the MSB.
REQ-024 For sub, carry_out SHALL be the carry out of A + ~B + 1, so carry_out=1 means no borrow.
REQ-025 For add and sub, overflow SHALL indicate two's-complement signed overflow.
REQ-026 For shifts, carry_out SHALL be the last bit shifted out, and overflow SHALL be 0.
REQ-027 For pass and the logic opcodes, carry_out SHALL be 0 and overflow SHALL be 0.
REQ-028 in_valid asserted while the block is not in IDLE SHALL have no effect.

Reset
REQ-029 Asserting reset SHALL immediately, without waiting for clk, force the state to IDLE and the counter to 0.
REQ-030 Asserting reset SHALL immediately force result=0, zero=0, negative=0, carry_out=0, overflow=0 and out_valid=0; in_ready SHALL be 1 during and after reset.
REQ-031 Reset asserted during SHIFT or DONE SHALL abandon the operation with no result delivered; the first accept after reset releases SHALL behave as from power-up.

Verification
REQ-032 With WIDTH=64, A=1, B=1, cntrl=010 accepted and out_ready=1, the bench SHALL see result=2, all flags 0, and out_valid high exactly one cycle after acceptance.
REQ-033 The bench SHALL check sub with A=5, B=5 -> result=0, zero=1, carry_out=1; and A=0, B=1 -> result=all-ones, negative=1, carry_out=0.
REQ-034 The bench SHALL check add with A=0x7FFF_FFFF_FFFF_FFFF, B=1 -> result=0x8000_0000_0000_0000, overflow=1, negative=1, carry_out=0.
REQ-035 The bench SHALL check LSL with A=0x8000_0000_0000_0001, B=4 -> result=0x10, carry_out=0, out_valid after 5 edges; and LSR with A=0x3, B=1 -> result=1, carry_out=1, out_valid after 2 edges.
REQ-036 The bench SHALL hold out_ready=0 for 3 cycles in DONE and check that result is stable, in_ready=0 and a pulsed in_valid is ignored; then with out_ready=1 the bench SHALL see IDLE on the next edge.
REQ-037 The bench SHALL assert reset mid-SHIFT (B=40) and check that out_valid=0, result=0 and in_ready=1 immediately, and that a following add completes normally.

Source files
------------

// File: rtl/alu_iter.sv
// ----------------------------------------------------------------------------
// alu_iter -- iterative ALU with valid/ready handshakes on both sides.
//
// Single-cycle opcodes (pass, add, sub, and, or, xor) finish one edge after
// acceptance. Logical shifts move one bit per cycle, so a shift by n takes
// n+1 edges from acceptance to out_valid.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   in_valid   in   request valid
//   in_ready   out  high only while idle (request can be accepted)
//   A, B       in   operands; B[SHW-1:0] is the shift amount for shifts
//   cntrl      in   opcode
//   out_valid  out  result and flags valid (held until out_ready)
//   out_ready  in   consumer takes the result
//   result     out  operation result
//   zero, negative, carry_out, overflow  out  status flags
// ----------------------------------------------------------------------------
module alu_iter #(
   parameter int WIDTH = 64,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       cntrl,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             negative,
   output logic             carry_out,
   output logic             overflow
);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StShift = 2'd1;
   localparam logic [1:0] StDone  = 2'd2;

   localparam logic [2:0] OpPass = 3'b000;
   localparam logic [2:0] OpLsl  = 3'b001;
   localparam logic [2:0] OpAdd  = 3'b010;
   localparam logic [2:0] OpSub  = 3'b011;
   localparam logic [2:0] OpAnd  = 3'b100;
   localparam logic [2:0] OpOr   = 3'b101;
   localparam logic [2:0] OpXor  = 3'b110;
   localparam logic [2:0] OpLsr  = 3'b111;

   logic [1:0]       state_q, state_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic             right_q, right_d;   // shift direction of the pending shift
   logic [WIDTH-1:0] result_q, result_d; // doubles as the shift working register
   logic             zero_q, zero_d;
   logic             neg_q, neg_d;
   logic             carry_q, carry_d;
   logic             ovf_q, ovf_d;

   // Single-cycle datapath on the live inputs; only used on the accept edge.
   logic [WIDTH:0]   add_full;
   logic [WIDTH:0]   sub_full;
   logic [WIDTH-1:0] alu_res;
   logic             alu_c;
   logic             alu_v;

   always_comb begin
      add_full = {1'b0, A} + {1'b0, B};
      sub_full = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
      alu_res  = B;
      alu_c    = 1'b0;
      alu_v    = 1'b0;
      unique case (cntrl)
         OpPass: alu_res = B;
         OpAdd: begin
            alu_res = add_full[WIDTH-1:0];
            alu_c   = add_full[WIDTH];
            // Same-sign operands giving a different-sign sum.
            alu_v   = (A[WIDTH-1] == B[WIDTH-1]) && (add_full[WIDTH-1] != A[WIDTH-1]);
         end
         OpSub: begin
            alu_res = sub_full[WIDTH-1:0];
            alu_c   = sub_full[WIDTH];
            // Different-sign operands with the difference taking B's sign.
            alu_v   = (A[WIDTH-1] != B[WIDTH-1]) && (sub_full[WIDTH-1] != A[WIDTH-1]);
         end
         OpAnd:   alu_res = A & B;
         OpOr:    alu_res = A | B;
         OpXor:   alu_res = A ^ B;
         OpLsl, OpLsr: alu_res = A;
         default: alu_res = B;
      endcase
   end

   logic [WIDTH-1:0] shifted;
   logic             shift_out;

   always_comb begin
      if (right_q) begin
         shifted   = {1'b0, result_q[WIDTH-1:1]};
         shift_out = result_q[0];
      end else begin
         shifted   = {result_q[WIDTH-2:0], 1'b0};
         shift_out = result_q[WIDTH-1];
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      right_d  = right_q;
      result_d = result_q;
      zero_d   = zero_q;
      neg_d    = neg_q;
      carry_d  = carry_q;
      ovf_d    = ovf_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               if (cntrl == OpLsl || cntrl == OpLsr) begin
                  result_d = A;
                  carry_d  = 1'b0;
                  ovf_d    = 1'b0;
                  right_d  = (cntrl == OpLsr);
                  cnt_d    = B[SHW-1:0];
                  if (B[SHW-1:0] == '0) begin
                     zero_d  = (A == '0);
                     neg_d   = A[WIDTH-1];
                     state_d = StDone;
                  end else begin
                     state_d = StShift;
                  end
               end else begin
                  result_d = alu_res;
                  carry_d  = alu_c;
                  ovf_d    = alu_v;
                  zero_d   = (alu_res == '0);
                  neg_d    = alu_res[WIDTH-1];
                  state_d  = StDone;
               end
            end
         end
         StShift: begin
            result_d = shifted;
            carry_d  = shift_out;
            cnt_d    = cnt_q - SHW'(1);
            if (cnt_q == SHW'(1)) begin
               zero_d  = (shifted == '0);
               neg_d   = shifted[WIDTH-1];
               ovf_d   = 1'b0;
               state_d = StDone;
            end
         end
         StDone: begin
            // Returning to idle only; a request cannot be taken on this edge.
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         right_q  <= 1'b0;
         result_q <= '0;
         zero_q   <= 1'b0;
         neg_q    <= 1'b0;
         carry_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         right_q  <= right_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         neg_q    <= neg_d;
         carry_q  <= carry_d;
         ovf_q    <= ovf_d;
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign result    = result_q;
   assign zero      = zero_q;
   assign negative  = neg_q;
   assign carry_out = carry_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_alu_iter.sv
// ----------------------------------------------------------------------------
// tb_alu_iter -- self-checking bench for alu_iter (WIDTH=64): directed corner
// cases plus randomized operations against a behavioural reference model.
// ----------------------------------------------------------------------------
module tb_alu_iter;

   localparam int W = 64;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  A;
   logic [W-1:0]  B;
   logic [2:0]    cntrl;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  result;
   logic          zero;
   logic          negative;
   logic          carry_out;
   logic          overflow;

   int n_checks = 0;
   int n_fail   = 0;

   alu_iter #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .cntrl     (cntrl),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .negative  (negative),
      .carry_out (carry_out),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model: expected result, flags and acceptance-to-valid latency.
   task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] res, output logic c, output logic v,
                        output int lat);
      logic [W:0] wide;
      logic [W:0] sx;
      int         n;
      n   = int'(b[5:0]);
      c   = 1'b0;
      v   = 1'b0;
      lat = 1;
      case (op)
         3'b000: res = b;
         3'b001: begin
            res = a << n;
            if (n > 0) c = a[W-n];
            lat = n + 1;
         end
         3'b010: begin
            wide = {1'b0, a} + {1'b0, b};
            res  = wide[W-1:0];
            c    = wide[W];
            sx   = {a[W-1], a} + {b[W-1], b};
            v    = sx[W] != sx[W-1];
         end
         3'b011: begin
            wide = {1'b0, a} + {1'b0, ~b} + 65'd1;
            res  = wide[W-1:0];
            c    = wide[W];
            sx   = {a[W-1], a} - {b[W-1], b};
            v    = sx[W] != sx[W-1];
         end
         3'b100: res = a & b;
         3'b101: res = a | b;
         3'b110: res = a ^ b;
         default: begin
            res = a >> n;
            if (n > 0) c = a[n-1];
            lat = n + 1;
         end
      endcase
   endtask

   // Issue one request, check latency/result/flags, stall `hold` cycles with
   // in_valid pulsed, then release and confirm the return to idle.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int hold);
      logic [W-1:0] er;
      logic         ec, ev;
      int           elat;
      int           edges;
      model(op, a, b, er, ec, ev, elat);
      @(negedge clk);
      check_eq({tag, ".in_ready_idle"}, W'(in_ready), W'(1));
      A        = a;
      B        = b;
      cntrl    = op;
      in_valid = 1'b1;
      @(posedge clk);
      edges = 1;
      @(negedge clk);
      // Scramble inputs after acceptance; they must be ignored.
      in_valid = 1'b0;
      A        = {$urandom, $urandom};
      B        = {$urandom, $urandom};
      cntrl    = 3'($urandom);
      while (!out_valid && edges < 100) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
      check_eq({tag, ".latency"}, W'(edges), W'(elat));
      check_eq({tag, ".result"}, result, er);
      check_eq({tag, ".zero"}, W'(zero), W'(er == '0));
      check_eq({tag, ".negative"}, W'(negative), W'(er[W-1]));
      check_eq({tag, ".carry"}, W'(carry_out), W'(ec));
      check_eq({tag, ".overflow"}, W'(overflow), W'(ev));
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1;
         @(posedge clk);
         @(negedge clk);
         check_eq({tag, ".hold_valid"}, W'(out_valid), W'(1));
         check_eq({tag, ".hold_ready"}, W'(in_ready), W'(0));
         check_eq({tag, ".hold_result"}, result, er);
      end
      // in_valid stays high across the release edge; it must not be accepted.
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check_eq({tag, ".rel_in_ready"}, W'(in_ready), W'(1));
      check_eq({tag, ".rel_out_valid"}, W'(out_valid), W'(0));
   endtask

   initial begin
      logic [2:0]   op;
      logic [W-1:0] ra, rb;
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      A         = '0;
      B         = '0;
      cntrl     = '0;
      #1;
      check_eq("rst.in_ready", W'(in_ready), W'(1));
      check_eq("rst.out_valid", W'(out_valid), W'(0));
      check_eq("rst.result", result, '0);
      check_eq("rst.flags", W'({zero, negative, carry_out, overflow}), W'(0));
      repeat (2) @(negedge clk);
      reset = 1'b0;

      run_op("add_1_1", 3'b010, 64'd1, 64'd1, 0);
      run_op("sub_eq", 3'b011, 64'd5, 64'd5, 0);
      run_op("sub_borrow", 3'b011, 64'd0, 64'd1, 1);
      run_op("add_ovf", 3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0);
      run_op("lsl4", 3'b001, 64'h8000_0000_0000_0001, 64'd4, 0);
      run_op("lsr1", 3'b111, 64'h3, 64'd1, 0);
      run_op("lsl0", 3'b001, 64'hDEAD_BEEF_0000_0001, 64'hFFFF_FFFF_FFFF_FFC0, 0);
      run_op("lsr63", 3'b111, 64'h8000_0000_0000_0000, 64'd63, 0);
      run_op("stall_and", 3'b100, 64'hF0F0_1234_5678_9ABC, 64'h0FF0_FFFF_0000_FFFF, 3);
      run_op("pass", 3'b000, 64'h1111, 64'h8000_0000_0000_0000, 0);

      // Reset in the middle of a long shift abandons it.
      @(negedge clk);
      A        = 64'hFFFF;
      B        = 64'd40;
      cntrl    = 3'b001;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (10) @(negedge clk);
      reset = 1'b1;
      #1;
      check_eq("midrst.out_valid", W'(out_valid), W'(0));
      check_eq("midrst.result", result, '0);
      check_eq("midrst.in_ready", W'(in_ready), W'(1));
      check_eq("midrst.flags", W'({zero, negative, carry_out, overflow}), W'(0));
      @(negedge clk);
      reset = 1'b0;
      run_op("post_rst_add", 3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 0);

      for (int k = 0; k < 40; k++) begin
         op = 3'($urandom);
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         if (k % 7 == 0) ra = 64'h8000_0000_0000_0000 ^ ra[7:0];
         if (k % 5 == 0) rb = ra;
         run_op($sformatf("rnd%0d_op%0d", k, op), op, ra, rb, int'($urandom_range(0, 2)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
